stream_match_monitor: RTL and testbench

//   Consumes the per-cycle 1-bit equality result (a XNOR b) from the XNOR compare stage.

---
 rtl/stream_match_pkg.sv | 14 +
 rtl/stream_match_monitor_sat_counter.sv | 23 ++
 rtl/stream_match_monitor.sv | 130 +++++++++++++
 tb/tb_stream_match_monitor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_match_pkg.sv
// Shared types and width helpers for the stream match monitor.
package stream_match_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } mon_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_match_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; feeds the lifetime error total.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    // Count up, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/stream_match_monitor.sv
// Lock acquisition and windowed error scoring on a per-cycle match stream.
// Optional lifetime error total enabled by defining STREAM_MATCH_STATS_EN.
module stream_match_monitor
    import stream_match_pkg::*;
#(
    parameter int unsigned LOCK_RUN  = 8,
    parameter int unsigned WINDOW    = 64,
    parameter int unsigned MAX_ERR   = 4,
    parameter int unsigned ERR_TOT_W = 16
) (
    input  logic                         clk,
    input  logic                         areset,
    input  logic                         clear,
    input  logic                         in_valid,
    input  logic                         in_match,
    output logic                         locked,
    output logic                         win_done,
    output logic [$clog2(WINDOW+1)-1:0]  win_errs,
    output logic                         lol,
    output logic [ERR_TOT_W-1:0]         err_total
);

    localparam int unsigned RW = cnt_w(LOCK_RUN);
    localparam int unsigned WW = cnt_w(WINDOW);
    localparam int unsigned EW = $clog2(WINDOW + 1);

    mon_state_t    state, state_nxt;
    logic [RW-1:0] run_cnt, run_cnt_nxt;
    logic [WW-1:0] win_cnt, win_cnt_nxt;
    logic [EW-1:0] err_cnt, err_cnt_nxt;
    logic [EW-1:0] win_errs_nxt;
    logic [EW-1:0] e;
    logic          win_done_nxt;
    logic          lol_nxt;

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state    <= SEARCH;
            run_cnt  <= '0;
            win_cnt  <= '0;
            err_cnt  <= '0;
            win_errs <= '0;
            win_done <= 1'b0;
            lol      <= 1'b0;
        end else begin
            state    <= state_nxt;
            run_cnt  <= run_cnt_nxt;
            win_cnt  <= win_cnt_nxt;
            err_cnt  <= err_cnt_nxt;
            win_errs <= win_errs_nxt;
            win_done <= win_done_nxt;
            lol      <= lol_nxt;
        end
    end

    // Next-state: lock search, window scoring and loss-of-lock decision.
    always_comb begin
        state_nxt    = state;
        run_cnt_nxt  = run_cnt;
        win_cnt_nxt  = win_cnt;
        err_cnt_nxt  = err_cnt;
        win_errs_nxt = win_errs;
        win_done_nxt = 1'b0;
        lol_nxt      = 1'b0;
        e            = err_cnt + EW'(~in_match);

        if (clear) begin
            // Restart discards any coincident sample and never signals lol.
            state_nxt    = SEARCH;
            run_cnt_nxt  = '0;
            win_cnt_nxt  = '0;
            err_cnt_nxt  = '0;
            win_errs_nxt = '0;
        end else if (in_valid) begin
            case (state)
                SEARCH: begin
                    if (!in_match) begin
                        run_cnt_nxt = '0;
                    end else if (run_cnt == RW'(LOCK_RUN - 1)) begin
                        state_nxt   = LOCKED;
                        run_cnt_nxt = '0;
                        win_cnt_nxt = '0;
                        err_cnt_nxt = '0;
                    end else begin
                        run_cnt_nxt = run_cnt + RW'(1);
                    end
                end
                LOCKED: begin
                    if (win_cnt == WW'(WINDOW - 1)) begin
                        win_errs_nxt = e;
                        win_done_nxt = 1'b1;
                        win_cnt_nxt  = '0;
                        err_cnt_nxt  = '0;
                        if (e > EW'(MAX_ERR)) begin
                            state_nxt   = SEARCH;
                            lol_nxt     = 1'b1;
                            run_cnt_nxt = '0;
                        end
                    end else begin
                        win_cnt_nxt = win_cnt + WW'(1);
                        err_cnt_nxt = e;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    assign locked = (state == LOCKED);

`ifdef STREAM_MATCH_STATS_EN
    logic tot_inc;

    assign tot_inc = in_valid & ~in_match & (state == LOCKED) & ~clear;

    sat_counter #(
        .WIDTH (ERR_TOT_W)
    ) u_err_total (
        .clk    (clk),
        .areset (areset),
        .inc    (tot_inc),
        .clr    (clear),
        .value  (err_total)
    );
`else
    assign err_total = '0;
`endif

endmodule

// File: tb/tb_stream_match_monitor.sv
// Scoreboarded bench for stream_match_monitor (ERR_TOT_W=4 to reach saturation).
module tb_stream_match_monitor;

    logic       clk = 1'b0;
    logic       areset;
    logic       clear;
    logic       in_valid;
    logic       in_match;
    logic       locked;
    logic       win_done;
    logic [6:0] win_errs;
    logic       lol;
    logic [3:0] err_total;

    typedef struct {
        int errs;
        int lol;
        int locked;
    } win_exp_t;

    win_exp_t exp_q[$];
    int chk_total = 0;
    int chk_pass  = 0;
    logic [63:0] mask;

`ifdef STREAM_MATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    stream_match_monitor #(
        .LOCK_RUN  (8),
        .WINDOW    (64),
        .MAX_ERR   (4),
        .ERR_TOT_W (4)
    ) dut (
        .clk       (clk),
        .areset    (areset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_match  (in_match),
        .locked    (locked),
        .win_done  (win_done),
        .win_errs  (win_errs),
        .lol       (lol),
        .err_total (err_total)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        chk_total++;
        if (act == exp) chk_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One cycle of stimulus; returns 1 time unit after the sampling edge.
    task automatic send(input logic v, input logic m);
        in_valid = v;
        in_match = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_matches(input int n);
        for (int i = 0; i < n; i++) send(1'b1, 1'b1);
    endtask

    // Full window of valid samples; set mask bits mark mismatches.
    task automatic send_window(input logic [63:0] mm);
        for (int i = 0; i < 64; i++) send(1'b1, ~mm[i]);
    endtask

    task automatic push_exp(input int errs, input int l, input int lk);
        win_exp_t x;
        x.errs = errs;
        x.lol = l;
        x.locked = lk;
        exp_q.push_back(x);
    endtask

    function automatic int tot(input int n);
        return STATS ? n : 0;
    endfunction

    // Monitor: every window-end pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (!areset) begin
            if (win_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_win_done", 1, 0);
                end else begin
                    win_exp_t x;
                    x = exp_q.pop_front();
                    check("win_errs", int'(win_errs), x.errs);
                    check("win_lol", int'(lol), x.lol);
                    check("win_locked", int'(locked), x.locked);
                end
            end else if (lol) begin
                check("lol_without_win_done", 1, 0);
            end
        end
    end

    initial begin
        areset = 1'b1;
        clear = 1'b0;
        in_valid = 1'b0;
        in_match = 1'b0;
        #12;
        check("rst_locked", int'(locked), 0);
        check("rst_win_done", int'(win_done), 0);
        check("rst_win_errs", int'(win_errs), 0);
        check("rst_lol", int'(lol), 0);
        check("rst_err_total", int'(err_total), 0);
        areset = 1'b0;
        @(posedge clk);
        #1;

        // Lock after exactly 8 consecutive matches.
        send_matches(7);
        check("t1_locked_after7", int'(locked), 0);
        send_matches(1);
        check("t1_locked_after8", int'(locked), 1);

        // A mismatch inside the run restarts the count.
        clear = 1'b1;
        send(1'b0, 1'b0);
        clear = 1'b0;
        check("t1_clear_unlock", int'(locked), 0);
        send_matches(7);
        send(1'b1, 1'b0);
        send_matches(7);
        check("t1_broken_run", int'(locked), 0);
        send_matches(1);
        check("t1_relock", int'(locked), 1);

        // Window with 4 mismatches stays locked.
        mask = '0;
        mask[10] = 1'b1; mask[20] = 1'b1; mask[30] = 1'b1; mask[40] = 1'b1;
        push_exp(4, 0, 1);
        send_window(mask);
        check("t2_locked", int'(locked), 1);
        check("t2_err_total", int'(err_total), tot(4));

        // Window with 5 mismatches, last one on the final sample, drops lock.
        mask = '0;
        mask[1] = 1'b1; mask[2] = 1'b1; mask[3] = 1'b1; mask[4] = 1'b1; mask[63] = 1'b1;
        push_exp(5, 1, 0);
        send_window(mask);
        check("t3_err_total", int'(err_total), tot(9));
        send_matches(1);
        check("t3_searching", int'(locked), 0);
        send_matches(7);
        check("t3_relock", int'(locked), 1);

        // Valid toggling: invalid cycles carry mismatches that must be ignored.
        for (int i = 0; i < 64; i++) begin
            if (i == 63) push_exp(2, 0, 1);
            send(1'b1, (i == 5 || i == 50) ? 1'b0 : 1'b1);
            send(1'b0, 1'b0);
        end
        check("t4_locked", int'(locked), 1);
        check("t4_err_total", int'(err_total), tot(11));

        // 20 mismatches in one window: lock lost, total saturates.
        mask = 64'(20'hFFFFF);
        push_exp(20, 1, 0);
        send_window(mask);
        check("t6_err_total_sat", int'(err_total), tot(15));
        check("t6_win_errs_hold", int'(win_errs), 20);

        // Asynchronous reset mid-window while locked.
        send_matches(8);
        send_matches(10);
        check("t5_pre_reset_locked", int'(locked), 1);
        areset = 1'b1;
        #1;
        check("t5_areset_locked", int'(locked), 0);
        check("t5_areset_win_errs", int'(win_errs), 0);
        check("t5_areset_err_total", int'(err_total), 0);
        #2;
        areset = 1'b0;
        @(posedge clk);
        #1;

        // Clear coincident with a window-ending mismatch: no score, no lol.
        send_matches(8);
        mask = '0;
        mask[0] = 1'b1; mask[1] = 1'b1; mask[2] = 1'b1; mask[3] = 1'b1;
        for (int i = 0; i < 63; i++) send(1'b1, ~mask[i]);
        check("t5_pre_clear_err_total", int'(err_total), tot(4));
        clear = 1'b1;
        send(1'b1, 1'b0);
        clear = 1'b0;
        check("t5_clear_locked", int'(locked), 0);
        check("t5_clear_lol", int'(lol), 0);
        check("t5_clear_win_done", int'(win_done), 0);
        check("t5_clear_err_total", int'(err_total), 0);
        send_matches(7);
        check("t5_run_restarted", int'(locked), 0);
        send_matches(1);
        check("t5_relock", int'(locked), 1);

        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        check("pending_windows", exp_q.size(), 0);
        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
